shifter_r_seq: RTL and testbench
================================

Name: shifter_r_seq

Overview:
- Multi-cycle registered right shifter: the right-shift counterpart of the pipeline's registered left shifter.
- Executes MIPS SRL/SRA/SRLV/SRAV one bit per cycle under a start/busy/done handshake.
- Sits beside the EX-stage ALU. The hazard unit stalls the pipeline while busy is high.
- Result is held in an output register until the next operation completes.

Parameters:
- n, 32, data width; must equal 2**SW.
- SW, 5, shift-amount width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- inp  input  n  operand to shift
- shamt  input  SW  shift amount, 0..n-1
- arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: out valid/updated
- out  output  n  result register

Behaviour:
- Reset (rst high at a clock edge): state IDLE; acc, cnt, arith_q, out cleared to 0; busy=0, done=0. Reset wins over every other input, including mid-operation; a partial result is discarded, out=0 and no done pulse.
- States: IDLE, SHIFT.
- IDLE:
  - done is 0 except in the cycle directly after completion.
  - On edge with start=1: acc<=inp, cnt<=shamt, arith_q<=arith, busy<=1, state<=SHIFT.
  - With start=0: nothing changes.
- SHIFT, cnt!=0: acc <= {fill, acc[n-1:1]}, where fill = arith_q ? acc[n-1] : 0; cnt<=cnt-1.
- SHIFT, cnt==0: out<=acc, done<=1, busy<=0, state<=IDLE.
- done is held 1 for exactly one cycle, then returns to 0.
- Latency: start sampled at edge k → done and out valid after edge k+shamt+1.
  - shamt=0 gives 1 cycle.
  - shamt=n-1 gives n cycles.
- Inputs are captured at start; changes to inp/shamt/arith while busy have no effect.
- start while busy is ignored, with no queueing.
- start asserted in the cycle done is high is accepted, since state is IDLE; back-to-back operations are legal.
- out changes only on completion or reset.
- busy is a registered signal, high from the edge after start through the edge that raises done.

Optional Feature:
- Macro: SHIFTER_R_FAST_EN.
- Defined: in SHIFT, if cnt>=4, acc shifts right by 4 with 4 fill bits and cnt<=cnt-4; otherwise the 1-bit step above applies.
  - Latency = floor(shamt/4) + (shamt mod 4) + 1.
  - Example: shamt=31 gives 11 cycles.
- Undefined: 1 bit per cycle only, with latency as in Behaviour.
- Results are identical in both builds.
- Handshake, reset and ignore rules are unchanged.

Decomposition:
- Package shifter_r_pkg holds:
  - state enum {IDLE, SHIFT};
  - the FAST_STEP=4 constant;
  - a function computing the fill vector from arith and msb.
- Sub-module shifter_r_step (combinational: acc, step size, arith → next acc) keeps the datapath separate from the FSM and is reused by both step sizes.

Test Plan (n=32):
1. inp=0x80000000, shamt=4, arith=0, start 1 cycle → done after 5 edges, out=0x08000000, busy high for 5 cycles.
2. Same operands with arith=1 → out=0xF8000000. With inp=0x7FFFFFF0, shamt=4, arith=1 → out=0x07FFFFFF.
3. shamt=0, inp=0x12345678 → done after 1 edge, out=0x12345678. inp=0x80000000, shamt=31, arith=1 → out=0xFFFFFFFF after 32 edges (11 with SHIFTER_R_FAST_EN).
4. start pulsed again mid-operation with different inp → ignored; first result unchanged. start asserted in the done cycle → second operation accepted and completes with the correct latency.
5. rst asserted 3 cycles into a shamt=20 operation → next edge gives busy=0, done=0, out=0, with no later done pulse. A fresh start then behaves normally.
6. Randomised 1000 operations compared against a reference model (>> or >>>), checking value and latency in both macro builds.

Source files
------------

// File: rtl/shifter_r_pkg.sv
// ---------------------------------------------------------------------------
// shifter_r_pkg
//   Shared definitions for the multi-cycle registered right shifter:
//   - state_t   : FSM states (IDLE, SHIFT)
//   - FAST_STEP : bits consumed per cycle by the optional wide step
//   - fill_vec  : fill bits shifted in at the MSB end (sign or zero)
// ---------------------------------------------------------------------------
package shifter_r_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int FAST_STEP = 4;

    // All-ones when sign-filling a negative operand, otherwise all-zeros.
    // Sized for the widest step; narrower steps only take the low bits.
    function automatic logic [FAST_STEP-1:0] fill_vec(input logic arith, input logic msb);
        return (arith && msb) ? {FAST_STEP{1'b1}} : {FAST_STEP{1'b0}};
    endfunction

endpackage

// File: rtl/shifter_r_step.sv
// ---------------------------------------------------------------------------
// shifter_r_step
//   Combinational right-shift step of STEP bit positions with sign or zero
//   fill. Shared by the 1-bit step and the optional 4-bit step.
//   Ports:
//     acc   in  [n-1:0]  current accumulator
//     arith in           1 = sign-fill from acc[n-1], 0 = zero-fill
//     nxt   out [n-1:0]  acc shifted right by STEP
// ---------------------------------------------------------------------------
module shifter_r_step
    import shifter_r_pkg::*;
#(
    parameter int n    = 32,
    parameter int STEP = 1
) (
    input  logic [n-1:0] acc,
    input  logic         arith,
    output logic [n-1:0] nxt
);

    logic [FAST_STEP-1:0] fill;

    assign fill = fill_vec(arith, acc[n-1]);

    // Shifting {fill, acc} right by STEP leaves {fill[STEP-1:0], acc[n-1:STEP]}
    // in the low n bits; the cast drops the spent fill bits above them.
    assign nxt = n'({fill, acc} >> STEP);

endmodule

// File: rtl/shifter_r_seq.sv
// ---------------------------------------------------------------------------
// shifter_r_seq
//   Multi-cycle registered right shifter (MIPS SRL/SRA/SRLV/SRAV) with a
//   start/busy/done handshake. Operands are captured on the start edge; the
//   accumulator then shifts one bit per cycle until the count is exhausted,
//   after which the result is written to out and done pulses for one cycle.
//   Latency from the start edge: shamt+1 edges.
//
//   Build option SHIFTER_R_FAST_EN: while at least FAST_STEP bits remain,
//   shift FAST_STEP bits per cycle (latency shamt/4 + shamt%4 + 1). Results
//   are identical in both builds.
//
//   n must equal 2**SW.
//
//   Ports:
//     clk   in            rising-edge clock
//     rst   in            synchronous active-high reset
//     start in            request, only honoured in IDLE
//     inp   in  [n-1:0]   operand
//     shamt in  [SW-1:0]  shift amount
//     arith in            1 = arithmetic, 0 = logical
//     busy  out           operation in progress (registered)
//     done  out           one-cycle pulse when out is updated
//     out   out [n-1:0]   result register
// ---------------------------------------------------------------------------
module shifter_r_seq
    import shifter_r_pkg::*;
#(
    parameter int n  = 32,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [n-1:0]  inp,
    input  logic [SW-1:0] shamt,
    input  logic          arith,
    output logic          busy,
    output logic          done,
    output logic [n-1:0]  out
);

    state_t        state, state_n;
    logic [n-1:0]  acc, acc_n, out_n, acc_one;
    logic [SW-1:0] cnt, cnt_n;
    logic          arith_q, arith_n, busy_n, done_n;

    shifter_r_step #(.n(n), .STEP(1)) u_step1 (
        .acc   (acc),
        .arith (arith_q),
        .nxt   (acc_one)
    );

`ifdef SHIFTER_R_FAST_EN
    logic [n-1:0] acc_fast;

    shifter_r_step #(.n(n), .STEP(FAST_STEP)) u_step_fast (
        .acc   (acc),
        .arith (arith_q),
        .nxt   (acc_fast)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            arith_q <= 1'b0;
            out     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            arith_q <= arith_n;
            out     <= out_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        arith_n = arith_q;
        out_n   = out;
        busy_n  = busy;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    acc_n   = inp;
                    cnt_n   = shamt;
                    arith_n = arith;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // The finishing cycle costs one edge even for shamt=0, so
                // done always follows the start edge by at least one cycle.
                if (cnt == '0) begin
                    out_n   = acc;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
`ifdef SHIFTER_R_FAST_EN
                else if (cnt >= SW'(FAST_STEP)) begin
                    acc_n = acc_fast;
                    cnt_n = cnt - SW'(FAST_STEP);
                end
`endif
                else begin
                    acc_n = acc_one;
                    cnt_n = cnt - SW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shifter_r_seq.sv
module tb_shifter_r_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] inp;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_out;   // bench model of the output register

    shifter_r_seq #(.n(32), .SW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .inp   (inp),
        .shamt (shamt),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_val(input logic [31:0] i, input int s, input logic a);
        logic signed [31:0] si;
        si = i;
        if (a) return 32'(si >>> s);
        return i >> s;
    endfunction

    function automatic int model_lat(input int s);
`ifdef SHIFTER_R_FAST_EN
        return s / 4 + s % 4 + 1;
`else
        return s + 1;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; returns #1 after that edge.
    task automatic issue(input logic [31:0] i, input logic [4:0] s, input logic a);
        inp   = i;
        shamt = s;
        arith = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done, checking busy and out hold while in flight. With
    // scramble set, operands and start are randomised during the operation.
    task automatic wait_done(input string tag, input bit scramble, output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            check({tag, ".busy"}, busy, 1'b1);
            check({tag, ".hold"}, out, exp_out);
            if (scramble) begin
                inp   = $urandom;
                shamt = 5'($urandom);
                arith = 1'($urandom);
                start = 1'($urandom);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
        start = 1'b0;
        if (!done) check({tag, ".timeout"}, 1'b0, 1'b1);
    endtask

    // Full operation with value/latency checks; returns in the done cycle.
    task automatic run_op(input string tag, input logic [31:0] i, input logic [4:0] s,
                          input logic a, input bit scramble);
        int cyc;
        logic [31:0] ev;
        ev = model_val(i, int'(s), a);
        issue(i, s, a);
        wait_done(tag, scramble, cyc);
        exp_out = ev;
        check({tag, ".lat"}, cyc, model_lat(int'(s)));
        check({tag, ".out"}, out, ev);
        check({tag, ".busy_end"}, busy, 1'b0);
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk);
        #1;
        check({tag, ".done_drop"}, done, 1'b0);
        check({tag, ".busy_idle"}, busy, 1'b0);
        check({tag, ".out_hold"}, out, exp_out);
    endtask

    initial begin
        int cyc, seen;
        logic [31:0] ri;
        logic [4:0]  rs;
        logic        ra;

        rst = 1'b1; start = 1'b0; inp = 32'hDEAD_BEEF; shamt = 5'd7; arith = 1'b1;
        exp_out = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.out", out, 32'h0);
        rst = 1'b0;

        // start=0 in IDLE leaves everything alone
        repeat (3) @(posedge clk);
        #1;
        check("idle.busy", busy, 1'b0);
        check("idle.out", out, 32'h0);

        // directed cases, consecutive run_op calls are back-to-back
        run_op("t1", 32'h8000_0000, 5'd4, 1'b0, 1'b0);
        check("t1.const", out, 32'h0800_0000);
        idle_check("t1");
        run_op("t2a", 32'h8000_0000, 5'd4, 1'b1, 1'b0);
        check("t2a.const", out, 32'hF800_0000);
        run_op("t2b", 32'h7FFF_FFF0, 5'd4, 1'b1, 1'b0);
        check("t2b.const", out, 32'h07FF_FFFF);
        run_op("t3a", 32'h1234_5678, 5'd0, 1'b0, 1'b0);
        check("t3a.const", out, 32'h1234_5678);
        run_op("t3b", 32'h8000_0000, 5'd31, 1'b1, 1'b0);
        check("t3b.const", out, 32'hFFFF_FFFF);
        idle_check("t3b");

        // in-flight start/operand changes are ignored
        run_op("t4", 32'hC3A5_0F0F, 5'd10, 1'b1, 1'b1);
        run_op("t4b2b", 32'h0F0F_1234, 5'd13, 1'b0, 1'b0);
        idle_check("t4");

        // reset mid-operation discards the partial result
        issue(32'hFFFF_0000, 5'd20, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_out = '0;
        check("t5.busy", busy, 1'b0);
        check("t5.done", done, 1'b0);
        check("t5.out", out, 32'h0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("t5.no_done", seen, 0);
        run_op("t5fresh", 32'h8765_4321, 5'd9, 1'b1, 1'b0);
        idle_check("t5fresh");

        // randomised operations against the reference model
        for (int k = 0; k < 1000; k++) begin
            ri = $urandom;
            rs = 5'($urandom);
            ra = 1'($urandom);
            run_op("rand", ri, rs, ra, 1'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                cyc = $urandom_range(1, 2);
                repeat (cyc) idle_check("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
